bsg_mcl_req_credit_arbiter: RTL and testbench

BSG_MCL_REQ_CREDIT_ARBITER -- requirements
Module: bsg_mcl_req_credit_arbiter

---
 rtl/cl_mcl_pkg.sv | 22 ++
 rtl/bsg_mcl_rr_picker.sv | 83 ++++++++
 rtl/bsg_mcl_req_credit_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bsg_mcl_req_credit_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cl_mcl_pkg.sv
// ---------------------------------------------------------------------------
// cl_mcl_pkg
//   Shared definitions for the MCL request credit arbiter slice:
//     - mcl_arb_state_e      : arbiter fence state machine encoding
//     - CL_MCL_DEFAULT_CREDITS : default endpoint credit ceiling
//     - cl_mcl_credit_width()  : width needed to hold 0..max credits
// ---------------------------------------------------------------------------
package cl_mcl_pkg;

   typedef enum logic [0:0] {
      ST_RUN        = 1'b0,
      ST_FENCE_WAIT = 1'b1
   } mcl_arb_state_e;

   localparam int CL_MCL_DEFAULT_CREDITS = 16;

   // Number of bits needed to represent the values 0..max_credits inclusive.
   function automatic int cl_mcl_credit_width(input int max_credits);
      return $clog2(max_credits + 1);
   endfunction

endpackage

// File: rtl/bsg_mcl_rr_picker.sv
// ---------------------------------------------------------------------------
// bsg_mcl_rr_picker
//   Round-robin picker: holds the last granted source and searches the
//   request vector starting one past it. The pointer only moves when a
//   grant is actually issued (en_i high and some request present).
//
//   Ports:
//     clk_i       : clock
//     reset_i     : synchronous active-high reset (pointer -> num_req_p-1)
//     req_i       : request vector
//     en_i        : grant enable for this cycle
//     grant_oh_o  : one-hot grant (all-zero when no grant)
//     id_o        : index of the selected source
//     v_o         : a grant is issued this cycle
// ---------------------------------------------------------------------------
module bsg_mcl_rr_picker #(
   parameter  int num_req_p = 2,
   localparam int id_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [num_req_p-1:0] req_i,
   input  logic                 en_i,
   output logic [num_req_p-1:0] grant_oh_o,
   output logic [id_w_lp-1:0]   id_o,
   output logic                 v_o
);

   logic [id_w_lp-1:0] last_q, last_d;
   logic [id_w_lp-1:0] pick_s;
   logic               found_s;

   // Candidate index at distance (off+1) past the last grant, wrapped.
   function automatic logic [id_w_lp-1:0] rr_idx(input logic [id_w_lp-1:0] last,
                                                  input int off);
      int t;
      t = int'(last) + 1 + off;
      if (t >= num_req_p) begin
         t = t - num_req_p;
      end else begin
         t = t;
      end
      return id_w_lp'(t);
   endfunction

   // Priority search beginning just after the last granted source.
   always_comb begin
      found_s = 1'b0;
      pick_s  = {id_w_lp{1'b0}};
      for (int i = 0; i < num_req_p; i++) begin
         if (!found_s && req_i[rr_idx(last_q, i)]) begin
            found_s = 1'b1;
            pick_s  = rr_idx(last_q, i);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grant outputs and pointer next-state.
   always_comb begin
      v_o        = found_s & en_i;
      id_o       = pick_s;
      grant_oh_o = {num_req_p{1'b0}};
      last_d     = last_q;
      if (v_o) begin
         grant_oh_o = num_req_p'(1'b1) << pick_s;
         last_d     = pick_s;
      end else begin
         last_d     = last_q;
      end
   end

   // Pointer register; reset gives source 0 first priority.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_q <= id_w_lp'(num_req_p - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/bsg_mcl_req_credit_arbiter.sv
// ---------------------------------------------------------------------------
// bsg_mcl_req_credit_arbiter
//   Round-robin arbiter from num_req_p host sources into a single endpoint,
//   gated by endpoint credits, with a registered one-entry output buffer.
//   Optional fence support is compiled in with `define BSG_MCL_ARB_FENCE_EN;
//   without it fence_i is ignored and fence_done_o is tied low.
//
//   Ports:
//     clk_i          : clock
//     reset_i        : synchronous active-high reset
//     v_i / data_i   : per-source request valid / packet (source k at
//                      data_i[k*width_p +: width_p])
//     ready_o        : per-source accept (one-hot on a grant, else zero)
//     v_o / data_o   : buffered packet to the endpoint (registered)
//     ready_i        : endpoint accept
//     out_credits_i  : endpoint credits available
//     grant_id_o     : source of the packet held in the buffer (registered)
//     fence_i        : fence request pulse
//     fence_done_o   : single-cycle fence completion
// ---------------------------------------------------------------------------
module bsg_mcl_req_credit_arbiter
   import cl_mcl_pkg::*;
#(
   parameter  int num_req_p         = 2,
   parameter  int width_p           = 128,
   parameter  int max_out_credits_p = CL_MCL_DEFAULT_CREDITS,
   localparam int cw_lp             = cl_mcl_credit_width(max_out_credits_p),
   localparam int id_w_lp           = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [num_req_p-1:0]         v_i,
   input  logic [num_req_p*width_p-1:0] data_i,
   output logic [num_req_p-1:0]         ready_o,
   output logic                         v_o,
   output logic [width_p-1:0]           data_o,
   input  logic                         ready_i,
   input  logic [cw_lp-1:0]             out_credits_i,
   output logic [id_w_lp-1:0]           grant_id_o,
   input  logic                         fence_i,
   output logic                         fence_done_o
);

   logic                 buf_v_q, buf_v_d;
   logic [width_p-1:0]   buf_data_q, buf_data_d;
   logic [id_w_lp-1:0]   buf_id_q, buf_id_d;

   logic                 deq_s;
   logic                 hold_s;
   logic                 buf_free_s;
   logic [cw_lp:0]       eff_credits_s;
   logic                 credit_ok_s;
   logic                 run_s;
   logic                 grant_en_s;
   logic                 grant_v_s;
   logic [num_req_p-1:0] grant_oh_s;
   logic [id_w_lp-1:0]   grant_id_s;
   logic [width_p-1:0]   data_arr_s [num_req_p];

   for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
      assign data_arr_s[g] = data_i[g*width_p +: width_p];
   end

   assign deq_s      = buf_v_q & ready_i;
   assign hold_s     = buf_v_q & ~ready_i;
   assign buf_free_s = ~buf_v_q | ready_i;

   // A held (non-dequeuing) packet already owns one credit; clamp at zero.
   always_comb begin
      eff_credits_s = {1'b0, out_credits_i};
      if (hold_s) begin
         if (out_credits_i != {cw_lp{1'b0}}) begin
            eff_credits_s = {1'b0, out_credits_i} - {{cw_lp{1'b0}}, 1'b1};
         end else begin
            eff_credits_s = {(cw_lp+1){1'b0}};
         end
      end else begin
         eff_credits_s = {1'b0, out_credits_i};
      end
   end

   assign credit_ok_s = (eff_credits_s != {(cw_lp+1){1'b0}});
   assign grant_en_s  = run_s & buf_free_s & credit_ok_s & ~reset_i;

`ifdef BSG_MCL_ARB_FENCE_EN
   mcl_arb_state_e state_q, state_d;
   logic           fence_done_s;

   // Fence FSM: stop granting until the buffer is empty and all credits are back.
   always_comb begin
      state_d      = state_q;
      fence_done_s = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (fence_i) begin
               state_d = ST_FENCE_WAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FENCE_WAIT: begin
            if (!buf_v_q && (out_credits_i == cw_lp'(max_out_credits_p))) begin
               fence_done_s = 1'b1;
               state_d      = ST_RUN;
            end else begin
               state_d      = ST_FENCE_WAIT;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Fence state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign run_s        = (state_q == ST_RUN);
   assign fence_done_o = fence_done_s & ~reset_i;
`else
   logic unused_fence_s;
   assign unused_fence_s = fence_i;
   assign run_s          = 1'b1;
   assign fence_done_o   = 1'b0;
`endif

   bsg_mcl_rr_picker #(
      .num_req_p (num_req_p)
   ) u_picker (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .req_i      (v_i),
      .en_i       (grant_en_s),
      .grant_oh_o (grant_oh_s),
      .id_o       (grant_id_s),
      .v_o        (grant_v_s)
   );

   assign ready_o = grant_oh_s;

   // Output buffer next-state: a grant refills it, a dequeue alone empties it.
   always_comb begin
      buf_v_d    = buf_v_q;
      buf_data_d = buf_data_q;
      buf_id_d   = buf_id_q;
      if (grant_v_s) begin
         buf_v_d    = 1'b1;
         buf_data_d = data_arr_s[grant_id_s];
         buf_id_d   = grant_id_s;
      end else if (deq_s) begin
         buf_v_d    = 1'b0;
      end else begin
         buf_v_d    = buf_v_q;
      end
   end

   // Output buffer registers; reset discards any held packet.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         buf_v_q    <= 1'b0;
         buf_data_q <= {width_p{1'b0}};
         buf_id_q   <= {id_w_lp{1'b0}};
      end else begin
         buf_v_q    <= buf_v_d;
         buf_data_q <= buf_data_d;
         buf_id_q   <= buf_id_d;
      end
   end

   assign v_o        = buf_v_q;
   assign data_o     = buf_data_q;
   assign grant_id_o = buf_id_q;

endmodule

// File: tb/tb_bsg_mcl_req_credit_arbiter.sv
module tb_bsg_mcl_req_credit_arbiter;

   localparam int NR = 2;
   localparam int W  = 128;
   localparam int MC = 16;
   localparam int CW = 5;

   logic            clk = 1'b0;
   logic            reset_i;
   logic [NR-1:0]   v_i;
   logic [NR*W-1:0] data_i;
   logic [NR-1:0]   ready_o;
   logic            v_o;
   logic [W-1:0]    data_o;
   logic            ready_i;
   logic [CW-1:0]   out_credits_i;
   logic [0:0]      grant_id_o;
   logic            fence_i;
   logic            fence_done_o;

   always #5 clk = ~clk;

   bsg_mcl_req_credit_arbiter #(
      .num_req_p         (NR),
      .width_p           (W),
      .max_out_credits_p (MC)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .v_i           (v_i),
      .data_i        (data_i),
      .ready_o       (ready_o),
      .v_o           (v_o),
      .data_o        (data_o),
      .ready_i       (ready_i),
      .out_credits_i (out_credits_i),
      .grant_id_o    (grant_id_o),
      .fence_i       (fence_i),
      .fence_done_o  (fence_done_o)
   );

   typedef struct packed {
      logic       rst;
      logic       fence;
      logic [1:0] v;
      logic       rdy;
      logic [4:0] cr;
      logic [1:0] e_rdy;
      logic       e_v;
      logic       e_gid;
      logic       e_fd;
   } vec_t;

   vec_t         tbl[$];
   logic [W-1:0] sb0[$];
   logic [W-1:0] sb1[$];
   int           seq[NR];
   int           checks;
   int           failures;

   function automatic vec_t mk(input int rst, input int fence, input int v, input int rdy,
                               input int cr, input int er, input int ev, input int eg,
                               input int ef);
      vec_t t;
      t.rst   = rst[0];
      t.fence = fence[0];
      t.v     = v[1:0];
      t.rdy   = rdy[0];
      t.cr    = cr[4:0];
      t.e_rdy = er[1:0];
      t.e_v   = ev[0];
      t.e_gid = eg[0];
      t.e_fd  = ef[0];
      return t;
   endfunction

   function automatic logic [W-1:0] pkt(input int k, input int s);
      return {4{8'(k), 24'(s)}};
   endfunction

   task automatic chk(input string nm, input int row, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
      end
   endtask

   // Drive one cycle, compare at the falling edge, update the scoreboard.
   task automatic apply(input vec_t t, input int row);
      logic [W-1:0] e;
      reset_i       = t.rst;
      fence_i       = t.fence;
      v_i           = t.v;
      ready_i       = t.rdy;
      out_credits_i = t.cr;
      for (int k = 0; k < NR; k++) begin
         data_i[k*W +: W] = pkt(k, seq[k]);
      end
      @(negedge clk);
      chk("ready_o", row, W'(ready_o), W'(t.e_rdy));
      chk("v_o", row, W'(v_o), W'(t.e_v));
      chk("grant_id_o", row, W'(grant_id_o), W'(t.e_gid));
      chk("fence_done_o", row, W'(fence_done_o), W'(t.e_fd));
      if (!t.rst && v_o && ready_i) begin
         if (grant_id_o == 1'b0) begin
            if (sb0.size() == 0) begin
               chk("sb0_nonempty", row, W'(0), W'(1));
            end else begin
               e = sb0.pop_front();
               chk("data_o_src0", row, data_o, e);
            end
         end else begin
            if (sb1.size() == 0) begin
               chk("sb1_nonempty", row, W'(0), W'(1));
            end else begin
               e = sb1.pop_front();
               chk("data_o_src1", row, data_o, e);
            end
         end
      end
      for (int k = 0; k < NR; k++) begin
         if (v_i[k] && ready_o[k]) begin
            if (k == 0) sb0.push_back(pkt(k, seq[k]));
            else        sb1.push_back(pkt(k, seq[k]));
            seq[k]++;
         end
      end
      @(posedge clk);
      #1;
      if (t.rst) begin
         sb0.delete();
         sb1.delete();
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      seq[0]        = 0;
      seq[1]        = 0;
      reset_i       = 1'b1;
      fence_i       = 1'b0;
      v_i           = 2'b00;
      ready_i       = 1'b0;
      out_credits_i = 5'd16;
      data_i        = '0;
      repeat (3) @(posedge clk);
      #1;

      //           rst fen v      rdy cr  e_rdy  e_v gid fd
      tbl.push_back(mk(0, 0, 2'b00, 0, 16, 2'b00, 0, 0, 0)); // reset state
      tbl.push_back(mk(0, 0, 2'b11, 1, 16, 2'b01, 0, 0, 0)); // alternate 0,1,0,1
      tbl.push_back(mk(0, 0, 2'b11, 1, 16, 2'b10, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b11, 1, 16, 2'b01, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b11, 1, 16, 2'b10, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b11, 0, 16, 2'b00, 1, 1, 0)); // ready_i toggling
      tbl.push_back(mk(0, 0, 2'b11, 1, 16, 2'b01, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b11, 0, 16, 2'b00, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b11, 1, 16, 2'b10, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b11, 0, 16, 2'b00, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b11, 1, 16, 2'b01, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b11, 0,  1, 2'b00, 1, 0, 0)); // 1 credit, buffer full
      tbl.push_back(mk(0, 0, 2'b11, 0,  1, 2'b00, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1,  1, 2'b00, 1, 0, 0)); // drain
      tbl.push_back(mk(0, 0, 2'b11, 1,  0, 2'b00, 0, 0, 0)); // no credits
      tbl.push_back(mk(0, 0, 2'b11, 1,  0, 2'b00, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b11, 1,  1, 2'b10, 0, 0, 0)); // credits rise
      tbl.push_back(mk(0, 0, 2'b11, 0,  1, 2'b00, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 16, 2'b00, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 16, 2'b00, 0, 1, 0));
      tbl.push_back(mk(0, 0, 2'b10, 1, 16, 2'b10, 0, 1, 0)); // single requester
      tbl.push_back(mk(0, 0, 2'b10, 1, 16, 2'b10, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b01, 1, 16, 2'b01, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 16, 2'b00, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 16, 2'b00, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end

      // Reset while a packet is held and the endpoint is stalled.
      apply(mk(0, 0, 2'b01, 0, 16, 2'b01, 0, 0, 0), 100);
      apply(mk(0, 0, 2'b00, 0, 16, 2'b00, 1, 0, 0), 101);
      apply(mk(1, 0, 2'b11, 0, 16, 2'b00, 1, 0, 0), 102);
      apply(mk(0, 0, 2'b11, 1, 16, 2'b01, 0, 0, 0), 103);
      apply(mk(0, 0, 2'b00, 1, 16, 2'b00, 1, 0, 0), 104);
      apply(mk(0, 0, 2'b00, 1, 16, 2'b00, 0, 0, 0), 105);

`ifdef BSG_MCL_ARB_FENCE_EN
      // Fence with credits outstanding; second fence pulse is ignored.
      apply(mk(0, 1, 2'b11, 1, 16, 2'b10, 0, 0, 0), 200);
      apply(mk(0, 0, 2'b11, 1, 15, 2'b00, 1, 1, 0), 201);
      apply(mk(0, 1, 2'b11, 1, 13, 2'b00, 0, 1, 0), 202);
      apply(mk(0, 0, 2'b11, 1, 14, 2'b00, 0, 1, 0), 203);
      apply(mk(0, 0, 2'b11, 1, 16, 2'b00, 0, 1, 1), 204);
      apply(mk(0, 0, 2'b11, 1, 16, 2'b01, 0, 1, 0), 205);
      apply(mk(0, 0, 2'b00, 1, 16, 2'b00, 1, 0, 0), 206);
      apply(mk(0, 0, 2'b00, 1, 16, 2'b00, 0, 0, 0), 207);
`else
      // Fence pulses have no effect on throughput.
      apply(mk(0, 1, 2'b11, 1, 16, 2'b10, 0, 0, 0), 200);
      apply(mk(0, 0, 2'b11, 1, 15, 2'b01, 1, 1, 0), 201);
      apply(mk(0, 1, 2'b11, 1, 13, 2'b10, 1, 0, 0), 202);
      apply(mk(0, 0, 2'b11, 1, 14, 2'b01, 1, 1, 0), 203);
      apply(mk(0, 0, 2'b11, 1, 16, 2'b10, 1, 0, 0), 204);
      apply(mk(0, 0, 2'b11, 1, 16, 2'b01, 1, 1, 0), 205);
      apply(mk(0, 0, 2'b00, 1, 16, 2'b00, 1, 0, 0), 206);
      apply(mk(0, 0, 2'b00, 1, 16, 2'b00, 0, 0, 0), 207);
`endif

      chk("sb0_leftover", 999, W'(sb0.size()), W'(0));
      chk("sb1_leftover", 999, W'(sb1.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
